// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port RAM between NCPU instruction/data cache ports
// Fixed class priority (write > data read > instruction read), round-robin within a class.
module mem_arbiter #(
   parameter int NCPU    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NCPU-1:0]      iREN,
   input  logic [32*NCPU-1:0]   iaddr,
   input  logic [NCPU-1:0]      dREN,
   input  logic [NCPU-1:0]      dWEN,
   input  logic [32*NCPU-1:0]   daddr,
   input  logic [32*NCPU-1:0]   dstore,
   output logic [NCPU-1:0]      iwait,
   output logic [NCPU-1:0]      dwait,
   output logic [32*NCPU-1:0]   iload,
   output logic [32*NCPU-1:0]   dload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore,
   input  logic [31:0]          ramload,
   input  logic                 ramready,
   output logic                 timeout_err
);

   localparam int CW   = (NCPU > 1) ? $clog2(NCPU) : 1;
   localparam int CNTW = $clog2(TIMEOUT);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
   localparam logic [31:0] ABORT_DATA = 32'hBAD1BAD1;

   typedef enum logic {IDLE, ACCESS} state_t;
   typedef enum logic [1:0] {C_IREAD, C_DREAD, C_DWRITE} cls_t;

   state_t               state_q, state_d;
   cls_t                 cls_q, cls_d;
   logic [CW-1:0]        rr_q, rr_d;
   logic [CW-1:0]        cpu_q, cpu_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          store_q, store_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 terr_q, terr_d;
   logic [32*NCPU-1:0]   iload_q, iload_d;
   logic [32*NCPU-1:0]   dload_q, dload_d;

   logic [NCPU-1:0]      req;
   cls_t                 win_cls;
   logic                 found;
   int                   win;
   int                   idx;
   logic                 done;
   logic [31:0]          rdata;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cls_q   <= C_IREAD;
         rr_q    <= '0;
         cpu_q   <= '0;
         addr_q  <= '0;
         store_q <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         rr_q    <= rr_d;
         cpu_q   <= cpu_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      rr_d    = rr_q;
      cpu_d   = cpu_q;
      addr_d  = addr_q;
      store_d = store_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      iload_d = iload_q;
      dload_d = dload_q;
      done    = 1'b0;
      found   = 1'b0;
      win     = 0;
      idx     = 0;
      rdata   = ramready ? ramload : ABORT_DATA;

      if (|dWEN) begin
         req     = dWEN;
         win_cls = C_DWRITE;
      end else if (|dREN) begin
         req     = dREN;
         win_cls = C_DREAD;
      end else begin
         req     = iREN;
         win_cls = C_IREAD;
      end

      // Search upward from rr+1, wrapping, so the last winner is checked last
      for (int k = 1; k <= NCPU; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NCPU) idx = idx - NCPU;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ACCESS;
               cpu_d   = CW'(win);
               cls_d   = win_cls;
               addr_d  = (win_cls == C_IREAD) ? iaddr[32*win +: 32] : daddr[32*win +: 32];
               store_d = dstore[32*win +: 32];
               cnt_d   = '0;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (ramready || cnt_q == CNT_LAST) begin
               done    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               rr_d    = cpu_q;
               if (!ramready) terr_d = 1'b1;
               if (cls_q == C_IREAD) iload_d[32*cpu_q +: 32] = rdata;
               else if (cls_q == C_DREAD) dload_d[32*cpu_q +: 32] = rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Completion is visible combinationally; a reset in that cycle suppresses the pulse
   always_comb begin
      iwait = '1;
      dwait = '1;
      iload = iload_q;
      dload = dload_q;
      if (done && !RST) begin
         if (cls_q == C_IREAD) begin
            iwait[cpu_q]            = 1'b0;
            iload[32*cpu_q +: 32]   = rdata;
         end else begin
            dwait[cpu_q] = 1'b0;
            if (cls_q == C_DREAD) dload[32*cpu_q +: 32] = rdata;
         end
      end
   end

   assign ramREN      = (state_q == ACCESS) && (cls_q != C_DWRITE);
   assign ramWEN      = (state_q == ACCESS) && (cls_q == C_DWRITE);
   assign ramaddr     = addr_q;
   assign ramstore    = store_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (NCPU=2, TIMEOUT=8)
module tb_mem_arbiter;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    iREN, dREN, dWEN;
   logic [63:0]   iaddr, daddr, dstore;
   logic [1:0]    iwait, dwait;
   logic [63:0]   iload, dload;
   logic          ramREN, ramWEN;
   logic [31:0]   ramaddr, ramstore, ramload;
   logic          ramready;
   logic          timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cpu;

   mem_arbiter #(.NCPU(2), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      iREN = '0; dREN = '0; dWEN = '0;
      ramready = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      do_reset();
      RST = 1'b1;
      tick();
      #1;
      check("rst_iwait", 32'(iwait), 32'h3);
      check("rst_dwait", 32'(dwait), 32'h3);
      check("rst_ramREN", 32'(ramREN), 32'h0);
      check("rst_ramWEN", 32'(ramWEN), 32'h0);
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_ramstore", ramstore, 32'h0);
      check("rst_terr", 32'(timeout_err), 32'h0);
      check("rst_iload0", iload[31:0], 32'h0);
      check("rst_dload1", dload[63:32], 32'h0);
      RST = 1'b0;
      tick();

      // Single instruction read, minimum latency
      iREN = 2'b01; iaddr[31:0] = 32'h40;
      #1;
      check("t1_idle_ramREN", 32'(ramREN), 32'h0);
      tick();
      iREN = '0; ramready = 1'b1; ramload = 32'hCAFE0001;
      #1;
      check("t1_ramREN", 32'(ramREN), 32'h1);
      check("t1_ramaddr", ramaddr, 32'h40);
      check("t1_iwait", 32'(iwait), 32'h2);
      check("t1_iload0", iload[31:0], 32'hCAFE0001);
      tick();
      ramready = 1'b0; ramload = 32'h0;
      #1;
      check("t1_iwait_after", 32'(iwait), 32'h3);
      check("t1_iload_hold", iload[31:0], 32'hCAFE0001);
      check("t1_ramREN_after", 32'(ramREN), 32'h0);

      // Write beats instruction read
      iREN = 2'b01; iaddr[31:0] = 32'h80;
      dWEN = 2'b10; daddr[63:32] = 32'h3100; dstore[63:32] = 32'h1234;
      tick();
      dWEN = '0;
      #1;
      check("t2_ramWEN", 32'(ramWEN), 32'h1);
      check("t2_ramREN", 32'(ramREN), 32'h0);
      check("t2_ramaddr", ramaddr, 32'h3100);
      check("t2_ramstore", ramstore, 32'h1234);
      ramready = 1'b1;
      #1;
      check("t2_dwait", 32'(dwait), 32'h1);
      check("t2_iwait_held", 32'(iwait), 32'h3);
      tick();
      ramready = 1'b0;
      tick();
      iREN = '0; ramready = 1'b1; ramload = 32'h5555;
      #1;
      check("t2_ird_ramREN", 32'(ramREN), 32'h1);
      check("t2_ird_ramaddr", ramaddr, 32'h80);
      check("t2_ird_iwait", 32'(iwait), 32'h2);
      check("t2_ird_iload0", iload[31:0], 32'h5555);
      tick();
      ramready = 1'b0;

      // Round-robin among continuous data reads, CPU1 first after reset
      do_reset();
      dREN = 2'b11; daddr = {32'h200, 32'h100};
      for (int g = 0; g < 4; g++) begin
         exp_cpu = (g % 2 == 0) ? 1 : 0;
         tick();
         #1;
         check($sformatf("t3_ramaddr_%0d", g), ramaddr, (exp_cpu == 1) ? 32'h200 : 32'h100);
         ramready = 1'b1; ramload = 32'hD000 + 32'(g);
         #1;
         check($sformatf("t3_dwait_%0d", g), 32'(dwait), (exp_cpu == 1) ? 32'h1 : 32'h2);
         check($sformatf("t3_dload_%0d", g), dload[32*exp_cpu +: 32], 32'hD000 + 32'(g));
         tick();
         ramready = 1'b0;
      end
      dREN = '0;
      tick();

      // Watchdog abort after 8 ACCESS cycles
      do_reset();
      dREN = 2'b01; daddr[31:0] = 32'h44;
      tick();
      dREN = '0;
      for (int i = 0; i < 7; i++) begin
         #1;
         check($sformatf("t4_dwait_%0d", i), 32'(dwait), 32'h3);
         check($sformatf("t4_ramREN_%0d", i), 32'(ramREN), 32'h1);
         tick();
      end
      #1;
      check("t4_abort_dwait", 32'(dwait), 32'h2);
      check("t4_abort_dload", dload[31:0], 32'hBAD1BAD1);
      check("t4_terr_before", 32'(timeout_err), 32'h0);
      tick();
      #1;
      check("t4_terr_set", 32'(timeout_err), 32'h1);
      check("t4_ramREN_idle", 32'(ramREN), 32'h0);
      check("t4_dwait_idle", 32'(dwait), 32'h3);
      iREN = 2'b01;
      tick();
      iREN = '0; ramready = 1'b1;
      tick();
      ramready = 1'b0;
      #1;
      check("t4_terr_sticky", 32'(timeout_err), 32'h1);
      do_reset();
      #1;
      check("t4_terr_cleared", 32'(timeout_err), 32'h0);

      // Reset during the second ACCESS cycle
      iREN = 2'b10; iaddr[63:32] = 32'h900;
      tick();
      iREN = '0; ramready = 1'b1;
      tick();
      ramready = 1'b0; iREN = 2'b10;
      tick();
      iREN = '0;
      #1;
      check("t5_ramREN", 32'(ramREN), 32'h1);
      check("t5_ramaddr", ramaddr, 32'h900);
      tick();
      RST = 1'b1;
      #1;
      check("t5_iwait_rst", 32'(iwait), 32'h3);
      tick();
      RST = 1'b0;
      #1;
      check("t5_ramREN_off", 32'(ramREN), 32'h0);
      check("t5_iwait_after", 32'(iwait), 32'h3);
      iREN = 2'b11; iaddr[31:0] = 32'hA00;
      tick();
      iREN = '0;
      #1;
      check("t5_rr_cleared", ramaddr, 32'h900);
      ramready = 1'b1;
      #1;
      check("t5_iwait_cpu1", 32'(iwait), 32'h1);
      tick();
      ramready = 1'b0;

      // dREN and dWEN together from one CPU act as a write
      dREN = 2'b01; dWEN = 2'b01; daddr[31:0] = 32'h77;
      tick();
      dREN = '0; dWEN = '0;
      #1;
      check("t6_ramWEN", 32'(ramWEN), 32'h1);
      check("t6_ramREN", 32'(ramREN), 32'h0);
      check("t6_ramaddr", ramaddr, 32'h77);
      ramready = 1'b1;
      #1;
      check("t6_dwait", 32'(dwait), 32'h2);
      tick();
      ramready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
